// File: rtl/powlib_ipsaxi_wr.sv
// AXI4 slave write responder: takes one AW burst and its W beats, replays them as a
// per-beat address/data/byte-enable stream, then answers with a single B response.
module powlib_ipsaxi_wr #(
    parameter int B_BPD     = 4,
    parameter int B_AW      = 32,
    parameter int MAX_BURST = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [B_AW-1:0]      awaddr,
    input  logic [7:0]           awlen,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awburst,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [8*B_BPD-1:0]   wdata,
    input  logic [B_BPD-1:0]     wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [B_AW-1:0]      wraddr,
    output logic [8*B_BPD-1:0]   wrdata,
    output logic [B_BPD-1:0]     wrbe,
    output logic                 wrvld,
    input  logic                 wrrdy
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam logic [2:0]      LOG_BPD = 3'($clog2(B_BPD));
    localparam logic [B_AW-1:0] ONE     = {{(B_AW-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic                r_awready;
    logic [B_AW-1:0]     r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_cnt;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_decErr;
    logic                r_protErr;
    logic [B_AW-1:0]     r_wraddr;
    logic [8*B_BPD-1:0]  r_wrdata;
    logic [B_BPD-1:0]    r_wrbe;
    logic                r_wrvld;

    logic                w_wready;
    logic                w_bvalid;
    logic                w_awHs;
    logic                w_wHs;
    logic                w_bHs;
    logic                w_awErr;
    logic [B_AW-1:0]     w_awStep;
    logic [B_AW-1:0]     w_step;
    logic [B_AW-1:0]     w_bound;
    logic [B_AW-1:0]     w_incr;
    logic [B_AW-1:0]     w_nextAddr;

    assign w_wready = (r_state == DATA) && (!r_wrvld || wrrdy);
    assign w_bvalid = (r_state == RESP) && !r_wrvld;
    assign w_awHs   = awvalid && r_awready;
    assign w_wHs    = wvalid && w_wready;
    assign w_bHs    = w_bvalid && bready;

    assign awready = r_awready;
    assign wready  = w_wready;
    assign bvalid  = w_bvalid;
    assign bresp   = (r_decErr || r_protErr) ? 2'd2 : 2'd0;
    assign wraddr  = r_wraddr;
    assign wrdata  = r_wrdata;
    assign wrbe    = r_wrbe;
    assign wrvld   = r_wrvld;

    // Burst legality is decided once at AW time; an illegal burst drains its beats silently.
    always_comb begin
        w_awStep = ONE << awsize;
        w_awErr  = 1'b0;
        if (awsize > LOG_BPD)
            w_awErr = 1'b1;
        if (awburst == 2'd3)
            w_awErr = 1'b1;
        if (({1'b0, awlen} + 9'd1) > 9'(MAX_BURST))
            w_awErr = 1'b1;
        if (awburst == 2'd2) begin
            if (!(awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15))
                w_awErr = 1'b1;
            if ((awaddr & (w_awStep - ONE)) != '0)
                w_awErr = 1'b1;
        end
    end

    always_comb begin
        w_step  = ONE << r_size;
        w_bound = (B_AW'(r_len) + ONE) << r_size;
        w_incr  = r_addr + w_step;
        case (r_burst)
            2'd1:    w_nextAddr = w_incr;
            2'd2:    w_nextAddr = (r_addr & ~(w_bound - ONE)) | (w_incr & (w_bound - ONE));
            default: w_nextAddr = r_addr;
        endcase
    end

    // A wlast mismatch only poisons the response; beats of a legally decoded burst still go out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_awready <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_decErr  <= 1'b0;
            r_protErr <= 1'b0;
            r_wraddr  <= '0;
            r_wrdata  <= '0;
            r_wrbe    <= '0;
            r_wrvld   <= 1'b0;
        end else begin
            if (r_wrvld && wrrdy)
                r_wrvld <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_awready <= 1'b1;
                    if (w_awHs) begin
                        r_awready <= 1'b0;
                        r_addr    <= awaddr;
                        r_len     <= awlen;
                        r_size    <= awsize;
                        r_burst   <= awburst;
                        r_cnt     <= '0;
                        r_decErr  <= w_awErr;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_wHs) begin
                        if (!r_decErr) begin
                            r_wraddr <= r_addr;
                            r_wrdata <= wdata;
                            r_wrbe   <= wstrb;
                            r_wrvld  <= 1'b1;
                        end
                        if (wlast != (r_cnt == r_len))
                            r_protErr <= 1'b1;
                        r_addr <= w_nextAddr;
                        if (r_cnt == r_len)
                            r_state <= RESP;
                        else
                            r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (w_bHs) begin
                        r_decErr  <= 1'b0;
                        r_protErr <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_powlib_ipsaxi_wr.sv
// Bench for powlib_ipsaxi_wr: directed and random bursts checked cycle by cycle
// against a per-beat address list and an expected downstream write queue.
module tb_powlib_ipsaxi_wr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] wraddr;
    logic [31:0] wrdata;
    logic [3:0]  wrbe;
    logic        wrvld;
    logic        wrrdy = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    powlib_ipsaxi_wr #(.B_BPD(4), .B_AW(32), .MAX_BURST(128)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe), .wrvld(wrvld), .wrrdy(wrrdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: wvalid/wrrdy/bready always high; 1: wrrdy toggles; 2: everything random
    task automatic runBurst(input logic [31:0] a, input int len, input int size,
                            input int burst, input int wlastIdx, input int mode);
        longint unsigned bytes, bound, base;
        logic [31:0] addrs[$];
        wr_t q[$];
        wr_t item;
        logic decErr, expErr, expWrvld, expWready, expBvalid, done;
        int beat, cyc;

        bytes  = 64'd1 << size;
        decErr = (size > 2) || (burst == 3) || (len + 1 > 128) ||
                 (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
                 (burst == 2 && (a % bytes) != 0);
        expErr = decErr || (wlastIdx != len);
        bound  = (longint'(len) + 1) * bytes;
        base   = (longint'(a) / bound) * bound;
        for (int i = 0; i <= len; i++) begin
            case (burst)
                0:       addrs.push_back(a);
                1:       addrs.push_back(32'(longint'(a) + i * bytes));
                default: addrs.push_back(32'(base + ((longint'(a) - base + i * bytes) % bound)));
            endcase
        end

        @(negedge clk);
        awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        #1;
        check("aw_ready", awready, 1'b1);
        check("idle_wready", wready, 1'b0);
        check("idle_bvalid", bvalid, 1'b0);

        beat = 0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            awvalid = 1'b0;
            if (beat <= len) begin
                wvalid = (mode == 0 || mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                wdata  = $urandom;
                wstrb  = 4'($urandom);
                wlast  = (beat == wlastIdx);
            end else begin
                wvalid = 1'b0;
                wlast  = 1'b0;
            end
            case (mode)
                0:       begin wrrdy = 1'b1; bready = 1'b1; end
                1:       begin wrrdy = cyc[0]; bready = 1'b1; end
                default: begin wrrdy = $urandom_range(0, 1) == 1; bready = $urandom_range(0, 1) == 1; end
            endcase
            #1;
            expWrvld  = q.size() != 0;
            expWready = (beat <= len) && (!expWrvld || wrrdy);
            expBvalid = (beat > len) && !expWrvld;
            check("wrvld", wrvld, expWrvld);
            if (expWrvld) begin
                check("wraddr", wraddr, q[0].a);
                check("wrdata", wrdata, q[0].d);
                check("wrbe", wrbe, q[0].s);
            end
            check("wready", wready, expWready);
            check("bvalid", bvalid, expBvalid);
            check("data_awready", awready, 1'b0);
            if (expBvalid)
                check("bresp", bresp, expErr ? 2'd2 : 2'd0);
            if (expWrvld && wrrdy)
                void'(q.pop_front());
            if (wvalid && expWready) begin
                if (!decErr) begin
                    item.a = addrs[beat];
                    item.d = wdata;
                    item.s = wstrb;
                    q.push_back(item);
                end
                beat++;
            end
            if (expBvalid && bready)
                done = 1'b1;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("[TB] FAIL burst_timeout: observed=not_done expected=done");
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_awready", awready, 1'b0);
        check("rst_wrvld", wrvld, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_bresp", bresp, 2'd0);
        check("rst_wraddr", wraddr, 32'd0);
        check("rst_wrdata", wrdata, 32'd0);
        check("rst_wrbe", wrbe, 4'd0);
        check("rst_wready", wready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        runBurst(32'h100, 3, 2, 1, 3, 0);
        runBurst(32'h108, 3, 2, 2, 3, 0);
        runBurst(32'h20,  2, 2, 0, 2, 1);
        runBurst(32'h40,  1, 2, 3, 1, 0);
        runBurst(32'h40,  1, 3, 1, 1, 0);
        runBurst(32'h200, 3, 2, 1, 1, 0);
        runBurst(32'h200, 3, 2, 1, 3, 0);
        runBurst(32'h102, 3, 2, 2, 3, 0);
        runBurst(32'h100, 2, 2, 2, 2, 0);
        runBurst(32'h303, 3, 2, 1, 3, 1);
        runBurst(32'h0,   129, 0, 1, 129, 0);

        // abort a long burst with reset while beats are in flight
        @(negedge clk);
        awaddr = 32'h400; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wrrdy = 1'b1;
        wvalid = 1'b1; wdata = 32'hA0; wstrb = 4'hF; wlast = 1'b0;
        @(negedge clk);
        wdata = 32'hA1;
        @(negedge clk);
        wdata = 32'hA2;
        #1;
        check("pre_rst_wrvld", wrvld, 1'b1);
        check("pre_rst_wraddr", wraddr, 32'h404);
        rst = 1'b0;
        #1;
        check("abort_wrvld", wrvld, 1'b0);
        check("abort_wready", wready, 1'b0);
        check("abort_bvalid", bvalid, 1'b0);
        check("abort_awready", awready, 1'b0);
        check("abort_wraddr", wraddr, 32'd0);
        @(negedge clk);
        wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        runBurst(32'h500, 0, 2, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int len, size, burst, wl;
            logic [31:0] a;
            len   = ($urandom_range(0, 3) == 0) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
            size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            a     = $urandom;
            if ($urandom_range(0, 1) == 1)
                a = a & ~((32'd1 << size) - 32'd1);
            wl    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
            runBurst(a, len, size, burst, wl, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/powlib_ipsaxi_wr.md
# powlib_ipsaxi_wr

AXI4 slave write-channel responder, the target-side counterpart of the AXI master write block. It accepts one AW burst at a time plus its W beats, expands the burst into a per-beat address/data/byte-enable write stream for local memory or register logic, and returns a single B response once every beat has been committed downstream. It sits between an AXI interconnect master port and the powlib on-chip write interface.

## Interface
- B_BPD, 4, bytes per data beat; power of two ≥1
- B_AW, 32, address width in bits
- MAX_BURST, 128, largest accepted burst in beats (awlen+1); ≤256

- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; asynchronous and active-low
- awaddr  in  B_AW  burst start address
- awlen  in  8  beats minus one
- awsize  in  3  log2 bytes per beat
- awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- awvalid / awready  in / out  1  AW handshake
- wdata  in  8*B_BPD  beat data
- wstrb  in  B_BPD  beat byte strobes
- wlast  in  1  final beat marker
- wvalid / wready  in / out  1  W handshake
- bresp  out  2  0 OKAY, 2 SLVERR
- bvalid / bready  out / in  1  B handshake
- wraddr  out  B_AW  beat address
- wrdata  out  8*B_BPD  beat data
- wrbe  out  B_BPD  beat byte enables
- wrvld / wrrdy  out / in  1  downstream write handshake

## Operation
- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1. On awvalid&awready: latch addr, len, size, burst; beat counter cnt=0; err flag set if any of: awsize > log2(B_BPD), awburst==3, awlen+1 > MAX_BURST, WRAP with awlen not in {1,3,7,15}, WRAP with awaddr not 2^awsize-aligned. Go to DATA.
- DATA: wready = !wrvld | wrrdy (one-entry output register). On W handshake:
  - if err clear: wraddr<=addr, wrdata<=wdata, wrbe<=wstrb, wrvld<=1; if err set: beat consumed, wrvld not raised.
  - wlast while cnt<len, or !wlast while cnt==len: set err.
  - address update: FIXED hold; INCR addr+(1<<size), B_AW-bit modulo; WRAP with bound=(len+1)<<size: addr=(addr & ~(bound-1)) | ((addr+(1<<size)) & (bound-1)).
  - cnt==len: go to RESP; else cnt+1.
- wrvld clears on wrvld&wrrdy with no new W beat in the same cycle; a simultaneous new beat reloads it (stays 1).
- RESP: bvalid = !wrvld (response only after last beat drained downstream). bresp = err ? 2 : 0. On bvalid&bready: clear err, go to IDLE.
- Only one outstanding burst; awready=0 outside IDLE.
- Beat address is not aligned down for unaligned INCR/FIXED starts; wrbe passes wstrb unmodified.

## Timing
- Reset (rst=0, asynchronous): state IDLE, cnt=0, err=0, wrvld=0, bvalid=0, bresp=0, wraddr/wrdata/wrbe=0, awready=0 while rst low; awready=1 from first clk edge after release.
- Reset mid-burst aborts immediately; no B response is issued for the aborted burst.
- AW handshake to first possible W acceptance: 1 cycle. W handshake to wrvld: 1 cycle. Full throughput 1 beat/cycle with wrrdy held high.
- Last W handshake at cycle N: bvalid earliest at N+2 (wrvld at N+1, drained at N+1 if wrrdy=1). Next awready earliest the cycle after B handshake.
- wready, awready, bvalid are functions of registered state only; no combinational path from any valid to any ready.
- wrvld/wraddr/wrdata/wrbe held stable while wrvld&!wrrdy.

## Test plan
- INCR awaddr=0x100, awlen=3, awsize=2, wrrdy=1 -> wraddr 0x100,0x104,0x108,0x10C on 4 consecutive cycles; bvalid 2 cycles after last W, bresp=0.
- WRAP awaddr=0x108, awlen=3, awsize=2 -> wraddr 0x108,0x10C,0x100,0x104; bresp=0.
- FIXED awaddr=0x20, awlen=2, wrrdy toggling 1/0 -> three writes all at 0x20, data unchanged while stalled, wready low when register full and wrrdy=0; bresp=0.
- awburst=3 (or awsize=3 with B_BPD=4) awlen=1 -> both beats consumed, wrvld never asserted, bresp=2.
- awlen=3 with wlast on beat 1 -> 4 beats written, bresp=2; next burst OKAY (err cleared).
- rst low during beat 2 of awlen=7 -> wrvld, bvalid, wready drop immediately; after release new burst awlen=0 completes with bresp=0.
